csr_req_arbiter: RTL and testbench

- Shares one CSR unit among NUM_REQS issue-side requesters using round-robin arbitration.
- Holds a grant from the sop handshake through the eop handshake, so multi-packet (PID-split) CSR instructions stay contiguous.
- For FPU CSR accesses, sequences a drain: it queries the scheduler's per-warp almost-empty status and forwards the request only once that warp has no pending instructions.
- Sits between the dispatch/issue slices and the CSR unit's execute interface.

---
 rtl/VX_gpu_pkg.sv | 16 +
 rtl/VX_rr_pick.sv | 37 +++
 rtl/csr_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_csr_req_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared types and helpers for the CSR request arbiter.
package VX_gpu_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        CSR_ARB_IDLE  = 2'd0,
        CSR_ARB_DRAIN = 2'd1,
        CSR_ARB_LOCK  = 2'd2
    } csr_arb_state_e;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int unsigned req_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/VX_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or above
// i_ptr, wrapping modulo NUM_REQS.
module VX_rr_pick
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    localparam int unsigned IDX_W = req_idx_w(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] i_valid,
    input  logic [IDX_W-1:0]    i_ptr,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_found
);

    int unsigned    w_pos;
    logic [IDX_W-1:0] w_cand;

    // Scan from the pointer upward; the first valid candidate wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_pos = 32'(i_ptr) + 32'(i);
            if (w_pos >= NUM_REQS) begin
                w_pos = w_pos - NUM_REQS;
            end
            w_cand = IDX_W'(w_pos);
            if (!o_found && i_valid[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one CSR unit among several issue requesters.
// Grants are held from sop to eop so split instructions stay contiguous, and
// FPU CSR accesses wait until their warp has drained.
module csr_req_arbiter
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 128,
    parameter int unsigned WID_W    = 4,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned IDX_W   = req_idx_w(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    output logic [NUM_REQS-1:0]       req_ready,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS*WID_W-1:0] req_wid,
    input  logic [NUM_REQS-1:0]       req_fpu,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [WID_W-1:0]          alm_empty_wid,
    input  logic                      alm_empty,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATAW-1:0]          out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      busy,
    output logic [CNT_W-1:0]          perf_drain_cycles
);

    csr_arb_state_e   r_state;
    csr_arb_state_e   w_state_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [CNT_W-1:0] r_perf;
    logic [CNT_W-1:0] w_perf_nxt;

    logic [IDX_W-1:0]    w_win_idx;
    logic                w_win_found;
    logic [IDX_W-1:0]    w_sel;
    logic [NUM_REQS-1:0] w_sel_oh;
    logic                w_fwd;
    logic                w_hs;
    logic                w_sel_eop;

    logic [DATAW-1:0] w_data_arr [NUM_REQS];
    logic [WID_W-1:0] w_wid_arr  [NUM_REQS];

    // sop is implied by the grant lock and carries no extra information here
    logic w_unused_sop;
    assign w_unused_sop = ^req_sop;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign w_data_arr[g] = req_data[g*DATAW +: DATAW];
        assign w_wid_arr[g]  = req_wid[g*WID_W +: WID_W];
    end

    VX_rr_pick #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_win_idx),
        .o_found (w_win_found)
    );

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (32'(idx) >= NUM_REQS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // In IDLE the live winner (or rr_ptr when nobody is valid) drives the
    // datapath; otherwise the latched grant does.
    assign w_sel = (r_state == CSR_ARB_IDLE) ? (w_win_found ? w_win_idx : r_rr_ptr)
                                             : r_grant_idx;
    assign w_sel_oh  = NUM_REQS'(1) << w_sel;
    assign w_sel_eop = req_eop[w_sel];

    // State register, pointers and drain counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= CSR_ARB_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_perf      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_perf      <= w_perf_nxt;
        end
    end

    // Next-state logic: drain entry, lock on multi-packet, pointer advance on eop.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_rr_nxt    = r_rr_ptr;
        w_perf_nxt  = r_perf;
        unique case (r_state)
            CSR_ARB_IDLE: begin
                if (w_win_found && req_fpu[w_win_idx] && !alm_empty) begin
                    w_grant_nxt = w_win_idx;
                    w_state_nxt = CSR_ARB_DRAIN;
                end else if (w_hs) begin
                    if (w_sel_eop) begin
                        w_rr_nxt = wrap_inc(w_win_idx);
                    end else begin
                        w_grant_nxt = w_win_idx;
                        w_state_nxt = CSR_ARB_LOCK;
                    end
                end
            end
            CSR_ARB_DRAIN: begin
                if (r_perf != '1) begin
                    w_perf_nxt = r_perf + 1'b1;
                end
                if (w_hs) begin
                    if (w_sel_eop) begin
                        w_rr_nxt    = wrap_inc(r_grant_idx);
                        w_state_nxt = CSR_ARB_IDLE;
                    end else begin
                        w_state_nxt = CSR_ARB_LOCK;
                    end
                end
            end
            CSR_ARB_LOCK: begin
                if (w_hs && w_sel_eop) begin
                    w_rr_nxt    = wrap_inc(r_grant_idx);
                    w_state_nxt = CSR_ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = CSR_ARB_IDLE;
            end
        endcase
    end

    // Outputs: forwarding is gated by reset so nothing leaks while it is held.
    always_comb begin
        w_fwd = 1'b0;
        unique case (r_state)
            CSR_ARB_IDLE:  w_fwd = w_win_found && (!req_fpu[w_sel] || alm_empty);
            CSR_ARB_DRAIN: w_fwd = req_valid[w_sel] && alm_empty;
            CSR_ARB_LOCK:  w_fwd = req_valid[w_sel];
            default:       w_fwd = 1'b0;
        endcase
        out_valid         = reset && w_fwd;
        w_hs              = out_valid && out_ready;
        req_ready         = w_hs ? w_sel_oh : '0;
        out_data          = w_data_arr[w_sel];
        out_idx           = w_sel;
        alm_empty_wid     = w_wid_arr[w_sel];
        busy              = (r_state != CSR_ARB_IDLE);
        perf_drain_cycles = r_perf;
    end

    // A granted requester must not withdraw mid-transaction.
    a_hold_valid: assert property (@(posedge clk) disable iff (!reset)
        (r_state != CSR_ARB_IDLE) |-> req_valid[r_grant_idx])
        else $error("csr_req_arbiter: granted requester dropped valid");

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Directed self-checking bench for csr_req_arbiter (NUM_REQS=4).
module tb_csr_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned WW = 4;
    localparam int unsigned CW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_data;
    logic [NR*WW-1:0] req_wid;
    logic [NR-1:0]   req_fpu;
    logic [NR-1:0]   req_sop;
    logic [NR-1:0]   req_eop;
    logic [WW-1:0]   alm_empty_wid;
    logic            alm_empty;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_idx;
    logic            busy;
    logic [CW-1:0]   perf_drain_cycles;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    csr_req_arbiter #(
        .NUM_REQS (NR),
        .DATAW    (DW),
        .WID_W    (WW),
        .CNT_W    (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_data          (req_data),
        .req_wid           (req_wid),
        .req_fpu           (req_fpu),
        .req_sop           (req_sop),
        .req_eop           (req_eop),
        .alm_empty_wid     (alm_empty_wid),
        .alm_empty         (alm_empty),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_idx           (out_idx),
        .busy              (busy),
        .perf_drain_cycles (perf_drain_cycles)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [127:0] pay(input int r, input int p);
        logic [127:0] v;
        v       = '0;
        v[31:0] = 32'hA000_0000 + 32'(r * 16 + p);
        return v;
    endfunction

    task automatic set_req(input int r, input logic v, input logic fpu, input logic sop,
                           input logic eop, input int p, input logic [WW-1:0] wid);
        req_valid[r]          = v;
        req_fpu[r]            = fpu;
        req_sop[r]            = sop;
        req_eop[r]            = eop;
        req_data[r*DW +: DW]  = pay(r, p);
        req_wid[r*WW +: WW]   = wid;
    endtask

    task automatic clear_all();
        for (int r = 0; r < NR; r++) begin
            set_req(r, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        alm_empty = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_fpu   = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_data  = '0;
        req_wid   = '0;

        // Reset held for 3 cycles with requests pending: nothing may be offered
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, 1'b1, 1'b1, 0, '0);
        repeat (3) cyc();
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(0));
        cyc();

        // Release with no requesters
        reset = 1'b1;
        clear_all();
        @(negedge clk);
        check("idle_out_valid", 128'(out_valid), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_req_ready", 128'(req_ready), 128'(0));
        check("idle_perf", 128'(perf_drain_cycles), 128'(0));
        cyc();

        // Round robin: all valid single-packet, one grant per cycle 0,1,2,3,0
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, 1'b1, 1'b1, r, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_valid", 128'(out_valid), 128'(1));
            check("rr_idx", 128'(out_idx), 128'(k % 4));
            check("rr_ready", 128'(req_ready), 128'(4'b0001 << (k % 4)));
            check("rr_data", out_data, pay(k % 4, k % 4));
            cyc();
        end
        clear_all();
        // rr_ptr now 1

        // Multi-packet lock on requester 1 while requester 2 waits
        set_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, '0);
        set_req(2, 1'b1, 1'b0, 1'b1, 1'b1, 0, '0);
        @(negedge clk);
        check("mp_p0_idx", 128'(out_idx), 128'(1));
        check("mp_p0_data", out_data, pay(1, 0));
        check("mp_p0_busy", 128'(busy), 128'(0));
        cyc();
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b0, 1, '0);
        @(negedge clk);
        check("mp_p1_idx", 128'(out_idx), 128'(1));
        check("mp_p1_data", out_data, pay(1, 1));
        check("mp_p1_busy", 128'(busy), 128'(1));
        check("mp_p1_ready", 128'(req_ready), 128'(4'b0010));
        cyc();
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 2, '0);
        @(negedge clk);
        check("mp_p2_idx", 128'(out_idx), 128'(1));
        check("mp_p2_data", out_data, pay(1, 2));
        cyc();
        set_req(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        check("mp_next_idx", 128'(out_idx), 128'(2));
        check("mp_next_busy", 128'(busy), 128'(0));
        check("mp_next_data", out_data, pay(2, 0));
        cyc();
        clear_all();
        // rr_ptr now 3

        // FPU drain: requester 0, warp 5, warp not empty for 4 cycles
        set_req(0, 1'b1, 1'b1, 1'b1, 1'b1, 4, 4'd5);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("drain_out_valid", 128'(out_valid), 128'(0));
            check("drain_wid", 128'(alm_empty_wid), 128'(5));
            check("drain_busy", 128'(busy), 128'(c > 1));
            cyc();
        end
        alm_empty = 1'b1;
        @(negedge clk);
        check("drain_fwd_valid", 128'(out_valid), 128'(1));
        check("drain_fwd_idx", 128'(out_idx), 128'(0));
        check("drain_fwd_ready", 128'(req_ready), 128'(4'b0001));
        check("drain_fwd_data", out_data, pay(0, 4));
        cyc();
        alm_empty = 1'b0;
        clear_all();
        @(negedge clk);
        check("drain_done_busy", 128'(busy), 128'(0));
        check("drain_perf", 128'(perf_drain_cycles), 128'(4));
        cyc();
        // rr_ptr now 1

        // Backpressure on a non-FPU request: payload held, no grant consumed
        set_req(2, 1'b1, 1'b0, 1'b1, 1'b1, 7, '0);
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_idx", 128'(out_idx), 128'(2));
            check("bp_data", out_data, pay(2, 7));
            check("bp_ready", 128'(req_ready), 128'(0));
            check("bp_busy", 128'(busy), 128'(0));
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 128'(req_ready), 128'(4'b0100));
        cyc();
        clear_all();
        // rr_ptr now 3: FPU request with warp already empty bypasses DRAIN
        set_req(3, 1'b1, 1'b1, 1'b1, 1'b1, 3, 4'd9);
        alm_empty = 1'b1;
        @(negedge clk);
        check("byp_valid", 128'(out_valid), 128'(1));
        check("byp_idx", 128'(out_idx), 128'(3));
        check("byp_wid", 128'(alm_empty_wid), 128'(9));
        check("byp_busy", 128'(busy), 128'(0));
        cyc();
        clear_all();
        alm_empty = 1'b0;
        @(negedge clk);
        check("byp_after_busy", 128'(busy), 128'(0));
        check("byp_perf", 128'(perf_drain_cycles), 128'(4));
        cyc();
        // rr_ptr now 0

        // Reset in the middle of a 2-packet lock
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, '0);
        set_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 0, '0);
        @(negedge clk);
        check("rl_sop_idx", 128'(out_idx), 128'(0));
        check("rl_sop_valid", 128'(out_valid), 128'(1));
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rl_rst_busy", 128'(busy), 128'(1));
        check("rl_rst_valid", 128'(out_valid), 128'(0));
        check("rl_rst_ready", 128'(req_ready), 128'(0));
        cyc();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, '0);
        @(negedge clk);
        check("rl_post_busy", 128'(busy), 128'(0));
        check("rl_post_idx", 128'(out_idx), 128'(0));
        check("rl_post_valid", 128'(out_valid), 128'(1));
        check("rl_post_perf", 128'(perf_drain_cycles), 128'(0));
        cyc();
        clear_all();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
